id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage MIPS pipeline, directly downstream of the register file.
//  - Captures regfile read data (data1/data2), immediate, register numbers and decoded control at the end of ID.
//  - Applies a write-through bypass for the same-cycle WB write. The regfile writes on posedge, so its read returns the old value.
//  - Detects load-use hazards and stalls ID/IF.
//  - Provides EX-stage forwarding from MEM and WB.
// PARAMETERS
//  DW          32  datapath width
//  CTRL_W      8   width of opaque decoded control bundle (ALUOp, ALUSrc, RegDst, MemWrite, Branch...)
//  STALLCNT_W  16  width of saturating load-use stall counter
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  rs_d, rt_d   in   5 each     ID source register numbers (same as regfile rs/rt)
//  rd_d         in   5          ID destination field
//  data1, data2 in   DW each    regfile read data for rs_d/rt_d
//  imm_d        in   DW         sign-extended immediate
//  ctrl_d       in   CTRL_W     decoded control, passed through
//  RegWrite_d   in   1          ID instruction writes a register
//  MemRead_d    in   1          ID instruction is a load
//  flush_d      in   1          kill the ID instruction (taken branch/jump); bubble enters EX
//  RegWrite_m   in   1          MEM-stage write enable
//  writereg_m   in   5          MEM-stage destination
//  aluout_m     in   DW         MEM-stage ALU result
//  RegWrite_w   in   1          WB write enable (same signal driving regfile RegWrite)
//  writereg_w   in   5          WB destination (same as regfile writereg)
//  writedate_w  in   DW         WB data (same as regfile writedate)
//  stall_d      out  1          combinational: hold PC and IF/ID this cycle
//  valid_e      out  1          EX holds a real instruction
//  rs_e, rt_e, rd_e  out  5 each   registered register numbers
//  srca_e       out  DW         forwarded operand A (combinational from registered A)
//  srcb_e       out  DW         forwarded operand B / store data
//  imm_e        out  DW         registered immediate
//  ctrl_e       out  CTRL_W     registered control
//  RegWrite_e   out  1          registered RegWrite, gated by valid
//  MemRead_e    out  1          registered MemRead, gated by valid
//  stall_cnt    out  STALLCNT_W load-use stall cycles since reset; saturates at all-ones
// BEHAVIOUR
//  Reset
//  - When reset=1 at a posedge, every registered output and the internal A/B registers clear to 0 (valid_e=0).
//  - stall_d is 0 while the stage holds a bubble.
//
//  Hazard detection
//  - hazard = valid_e & MemRead_e & (rt_e!=0) & ((rt_e==rs_d) | (rt_e==rt_d)).
//  - stall_d = hazard & ~flush_d.
//
//  Capture (each posedge, reset=0)
//  - Bubble case (stall_d | flush_d):
//    - valid_e, RegWrite_e, MemRead_e and ctrl_e load 0.
//    - Other fields are don't-care; the implementation loads 0.
//  - Otherwise:
//    - All _d fields load into _e; valid_e=1.
//    - A loads data1, replaced by writedate_w when RegWrite_w & writereg_w==rs_d & rs_d!=0.
//    - B uses the same rule with rt_d/data2.
//  - Latency: exactly one cycle ID->EX, with no internal queueing.
//
//  EX forwarding (combinational, per operand, operand number r = rs_e or rt_e)
//  - If r==0: output 0.
//  - Else if RegWrite_m & writereg_m==r: aluout_m.
//  - Else if RegWrite_w & writereg_w==r: writedate_w.
//  - Else: the registered A/B value.
//  - MEM has priority over WB (youngest producer wins).
//
//  Stall counter
//  - Increments by 1 on each posedge where stall_d=1; holds at 2^STALLCNT_W-1.
//  - Clears only on reset.
//
//  Boundary conditions
//  - $zero: register 0 is never bypassed or forwarded, even if writereg==0 with RegWrite=1.
//  - flush_d and hazard together: flush wins and stall_d=0, since the younger instruction is being killed.
//  - Back-to-back load-use: a stall inserts exactly one bubble. The next cycle valid_e=0, so no second stall.
//  - Reset mid-stall: the next cycle has valid_e=0, stall_d=0 and stall_cnt=0.
// TESTING
//  1. Reset: assert reset for 2 cycles with random inputs -> all outputs 0, valid_e=0, stall_cnt=0.
//  2. WB bypass:
//     - Stimulus: rs_d=5, data1=32'h11, RegWrite_w=1, writereg_w=5, writedate_w=32'hAA, no MEM/WB match in EX.
//     - Required: next cycle srca_e=32'hAA.
//     - Repeat with rs_d=0 -> srca_e=0.
//  3. MEM priority:
//     - Stimulus: rs_e=rt_e=7, RegWrite_m=1, writereg_m=7, aluout_m=32'h1; RegWrite_w=1, writereg_w=7, writedate_w=32'h2.
//     - Required: srca_e=srcb_e=32'h1.
//     - Drop RegWrite_m -> both 32'h2.
//  4. Load-use:
//     - Stimulus: lw to r3 in EX (MemRead_e=1, rt_e=3) with rs_d=3.
//     - Required: stall_d=1 for exactly 1 cycle; next cycle valid_e=0, RegWrite_e=0; stall_cnt=1.
//     - Then the held instruction enters EX with valid_e=1.
//  5. Flush+hazard:
//     - Stimulus: same as scenario 4 plus flush_d=1.
//     - Required: stall_d=0, bubble enters EX, stall_cnt unchanged.
//  6. Saturation: STALLCNT_W=2, force 5 consecutive load-use stalls -> stall_cnt = 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a 5-stage MIPS pipeline.
// It captures the register file read data, with a write-through bypass for the
// same-cycle WB write. It detects load-use hazards, drives a stall back to
// IF/ID, and forwards EX operands from MEM and WB.
module id_ex_stage #(
    parameter int DW         = 32,
    parameter int CTRL_W     = 8,
    parameter int STALLCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            rs_d,
    input  logic [4:0]            rt_d,
    input  logic [4:0]            rd_d,
    input  logic [DW-1:0]         data1,
    input  logic [DW-1:0]         data2,
    input  logic [DW-1:0]         imm_d,
    input  logic [CTRL_W-1:0]     ctrl_d,
    input  logic                  RegWrite_d,
    input  logic                  MemRead_d,
    input  logic                  flush_d,
    input  logic                  RegWrite_m,
    input  logic [4:0]            writereg_m,
    input  logic [DW-1:0]         aluout_m,
    input  logic                  RegWrite_w,
    input  logic [4:0]            writereg_w,
    input  logic [DW-1:0]         writedate_w,
    output logic                  stall_d,
    output logic                  valid_e,
    output logic [4:0]            rs_e,
    output logic [4:0]            rt_e,
    output logic [4:0]            rd_e,
    output logic [DW-1:0]         srca_e,
    output logic [DW-1:0]         srcb_e,
    output logic [DW-1:0]         imm_e,
    output logic [CTRL_W-1:0]     ctrl_e,
    output logic                  RegWrite_e,
    output logic                  MemRead_e,
    output logic [STALLCNT_W-1:0] stall_cnt
);

    // Registered operand values, before EX forwarding is applied
    logic [DW-1:0] a_e;
    logic [DW-1:0] b_e;
    logic          hazard;
    logic          bubble;
    logic [DW-1:0] a_byp;
    logic [DW-1:0] b_byp;

    // The regfile write lands on the same edge we capture, so its read port still
    // shows the old value. Register 0 never takes a bypass.
    function automatic logic [DW-1:0] wb_bypass(
        input logic [4:0]    r,
        input logic [DW-1:0] rdata,
        input logic          we_w,
        input logic [4:0]    wr_w,
        input logic [DW-1:0] wd_w
    );
        if (we_w && (wr_w == r) && (r != 5'd0))
            return wd_w;
        return rdata;
    endfunction

    // When both MEM and WB write the register, MEM holds the younger producer and wins
    function automatic logic [DW-1:0] ex_forward(
        input logic [4:0]    r,
        input logic [DW-1:0] held,
        input logic          we_m,
        input logic [4:0]    wr_m,
        input logic [DW-1:0] res_m,
        input logic          we_w,
        input logic [4:0]    wr_w,
        input logic [DW-1:0] wd_w
    );
        if (r == 5'd0)
            return '0;
        if (we_m && (wr_m == r))
            return res_m;
        if (we_w && (wr_w == r))
            return wd_w;
        return held;
    endfunction

    // Saturating increment: the counter holds once it reaches all-ones
    function automatic logic [STALLCNT_W-1:0] sat_inc(input logic [STALLCNT_W-1:0] cnt);
        if (&cnt)
            return cnt;
        return cnt + STALLCNT_W'(1);
    endfunction

    // Load-use hazard detection. A flush kills the dependent instruction, so it cancels the stall.
    always_comb begin
        hazard  = valid_e & MemRead_e & (rt_e != 5'd0) & ((rt_e == rs_d) | (rt_e == rt_d));
        stall_d = hazard & ~flush_d;
        bubble  = stall_d | flush_d;
        a_byp   = wb_bypass(rs_d, data1, RegWrite_w, writereg_w, writedate_w);
        b_byp   = wb_bypass(rt_d, data2, RegWrite_w, writereg_w, writedate_w);
    end

    // ID -> EX capture. A bubble clears every field, including the don't-care ones.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_e    <= 1'b0;
            RegWrite_e <= 1'b0;
            MemRead_e  <= 1'b0;
            ctrl_e     <= '0;
            rs_e       <= '0;
            rt_e       <= '0;
            rd_e       <= '0;
            imm_e      <= '0;
            a_e        <= '0;
            b_e        <= '0;
        end else begin
            valid_e    <= 1'b1;
            RegWrite_e <= RegWrite_d;
            MemRead_e  <= MemRead_d;
            ctrl_e     <= ctrl_d;
            rs_e       <= rs_d;
            rt_e       <= rt_d;
            rd_e       <= rd_d;
            imm_e      <= imm_d;
            a_e        <= a_byp;
            b_e        <= b_byp;
        end
    end

    // Count load-use stall cycles since reset
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_d)
            stall_cnt <= sat_inc(stall_cnt);
    end

    // EX operand forwarding from MEM and WB
    always_comb begin
        srca_e = ex_forward(rs_e, a_e, RegWrite_m, writereg_m, aluout_m,
                            RegWrite_w, writereg_w, writedate_w);
        srcb_e = ex_forward(rt_e, b_e, RegWrite_m, writereg_m, aluout_m,
                            RegWrite_w, writereg_w, writedate_w);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a stimulus process drives directed and random
// ID/MEM/WB traffic and pushes expected snapshots. A monitor process pops them and compares.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [31:0] data1, data2, imm_d;
    logic [7:0]  ctrl_d;
    logic        RegWrite_d, MemRead_d, flush_d;
    logic        RegWrite_m;
    logic [4:0]  writereg_m;
    logic [31:0] aluout_m;
    logic        RegWrite_w;
    logic [4:0]  writereg_w;
    logic [31:0] writedate_w;

    logic        stall_d, valid_e, RegWrite_e, MemRead_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [31:0] srca_e, srcb_e, imm_e;
    logic [7:0]  ctrl_e;
    logic [15:0] stall_cnt;

    logic        stall_s, valid_s, RegWrite_s, MemRead_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [31:0] srca_s, srcb_s, imm_s;
    logic [7:0]  ctrl_s;
    logic [1:0]  stall_cnt_s;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .data1(data1), .data2(data2), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .RegWrite_d(RegWrite_d), .MemRead_d(MemRead_d), .flush_d(flush_d),
        .RegWrite_m(RegWrite_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
        .RegWrite_w(RegWrite_w), .writereg_w(writereg_w), .writedate_w(writedate_w),
        .stall_d(stall_d), .valid_e(valid_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
        .srca_e(srca_e), .srcb_e(srcb_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
        .RegWrite_e(RegWrite_e), .MemRead_e(MemRead_e), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy driven by the same inputs, for saturation
    id_ex_stage #(.STALLCNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .data1(data1), .data2(data2), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .RegWrite_d(RegWrite_d), .MemRead_d(MemRead_d), .flush_d(flush_d),
        .RegWrite_m(RegWrite_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
        .RegWrite_w(RegWrite_w), .writereg_w(writereg_w), .writedate_w(writedate_w),
        .stall_d(stall_s), .valid_e(valid_s), .rs_e(rs_s), .rt_e(rt_s), .rd_e(rd_s),
        .srca_e(srca_s), .srcb_e(srcb_s), .imm_e(imm_s), .ctrl_e(ctrl_s),
        .RegWrite_e(RegWrite_s), .MemRead_e(MemRead_s), .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the EX stage holds, as an instruction record
    typedef struct {
        bit          valid;
        bit          rw;
        bit          mr;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [7:0]  ctrl;
    } instr_t;

    typedef struct {
        bit          full;
        bit          valid, rw, mr, stall;
        logic [7:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, srca, srcb;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } snap_t;

    instr_t      ex;
    bit          fresh;
    int unsigned stalls;
    snap_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          done = 0;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0) return 32'h0;
        if (RegWrite_m && writereg_m == r) return aluout_m;
        if (RegWrite_w && writereg_w == r) return writedate_w;
        return held;
    endfunction

    function automatic logic [31:0] regread(input logic [4:0] r, input logic [31:0] rdata);
        if (r != 5'd0 && RegWrite_w && writereg_w == r) return writedate_w;
        return rdata;
    endfunction

    task automatic idle();
        reset = 0; flush_d = 0;
        rs_d = 0; rt_d = 0; rd_d = 0; data1 = 0; data2 = 0; imm_d = 0; ctrl_d = 0;
        RegWrite_d = 0; MemRead_d = 0;
        RegWrite_m = 0; writereg_m = 0; aluout_m = 0;
        RegWrite_w = 0; writereg_w = 0; writedate_w = 0;
    endtask

    task automatic rand_inputs();
        reset = 0;
        rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
        rd_d = 5'($urandom_range(0, 31));
        data1 = $urandom; data2 = $urandom; imm_d = $urandom; ctrl_d = 8'($urandom);
        RegWrite_d = 1'($urandom); MemRead_d = 1'($urandom);
        flush_d = ($urandom_range(0, 7) == 0);
        RegWrite_m = 1'($urandom); writereg_m = 5'($urandom_range(0, 7)); aluout_m = $urandom;
        RegWrite_w = 1'($urandom); writereg_w = 5'($urandom_range(0, 7)); writedate_w = $urandom;
    endtask

    // Push what should be visible now, advance the model one clock, then move to the next negedge
    task automatic step();
        snap_t s;
        bit    stl;
        stl = ex.valid && ex.mr && ex.rt != 0 && (ex.rt == rs_d || ex.rt == rt_d) && !flush_d;
        s.full = fresh; s.valid = ex.valid; s.rw = ex.rw; s.mr = ex.mr; s.ctrl = ex.ctrl;
        s.rs = ex.rs; s.rt = ex.rt; s.rd = ex.rd; s.imm = ex.imm;
        s.srca = fwd(ex.rs, ex.a); s.srcb = fwd(ex.rt, ex.b);
        s.stall = stl;
        s.cnt = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
        s.cnt2 = (stalls > 3) ? 2'd3 : 2'(stalls);
        exp_q.push_back(s);
        if (reset) begin
            ex = '{default: 0}; stalls = 0; fresh = 1;
        end else if (stl || flush_d) begin
            ex = '{default: 0}; fresh = 0;
            if (stl) stalls++;
        end else begin
            ex.valid = 1; ex.rw = RegWrite_d; ex.mr = MemRead_d; ex.ctrl = ctrl_d;
            ex.rs = rs_d; ex.rt = rt_d; ex.rd = rd_d; ex.imm = imm_d;
            ex.a = regread(rs_d, data1); ex.b = regread(rt_d, data2);
            fresh = 0;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle, compare the DUT against the oldest expected snapshot
    always @(negedge clk) begin
        snap_t s;
        #2;
        if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            chk("valid_e", 32'(valid_e), 32'(s.valid));
            chk("RegWrite_e", 32'(RegWrite_e), 32'(s.rw));
            chk("MemRead_e", 32'(MemRead_e), 32'(s.mr));
            chk("ctrl_e", 32'(ctrl_e), 32'(s.ctrl));
            chk("stall_d", 32'(stall_d), 32'(s.stall));
            chk("stall_cnt", 32'(stall_cnt), 32'(s.cnt));
            chk("stall_cnt_sat", 32'(stall_cnt_s), 32'(s.cnt2));
            if (s.full || s.valid) begin
                chk("rs_e", 32'(rs_e), 32'(s.rs));
                chk("rt_e", 32'(rt_e), 32'(s.rt));
                chk("rd_e", 32'(rd_e), 32'(s.rd));
                chk("imm_e", imm_e, s.imm);
                chk("srca_e", srca_e, s.srca);
                chk("srcb_e", srcb_e, s.srcb);
            end
        end
    end

    initial begin
        ex = '{default: 0}; fresh = 1; stalls = 0;
        rand_inputs(); reset = 1;
        @(negedge clk);
        // Reset held with random inputs
        for (int i = 0; i < 2; i++) begin rand_inputs(); reset = 1; step(); end
        // WB write-through bypass, then the same with rs=0
        idle(); rs_d = 5; data1 = 32'h11; RegWrite_w = 1; writereg_w = 5; writedate_w = 32'hAA; step();
        idle(); step();
        idle(); rs_d = 0; data1 = 32'h11; RegWrite_w = 1; writereg_w = 0; writedate_w = 32'hAA; step();
        idle(); step();
        // MEM over WB priority on r7, then WB only
        idle(); rs_d = 7; rt_d = 7; data1 = 32'h77; data2 = 32'h78; step();
        RegWrite_m = 1; writereg_m = 7; aluout_m = 32'h1;
        RegWrite_w = 1; writereg_w = 7; writedate_w = 32'h2; step();
        RegWrite_m = 0; step();
        // Load-use: lw r3, then a dependent instruction held for one cycle
        idle(); MemRead_d = 1; RegWrite_d = 1; rs_d = 1; rt_d = 3; step();
        idle(); rs_d = 3; rt_d = 4; RegWrite_d = 1; ctrl_d = 8'h5A; step();
        step();
        idle(); step();
        // Flush together with a hazard
        idle(); MemRead_d = 1; RegWrite_d = 1; rs_d = 1; rt_d = 3; step();
        idle(); rs_d = 3; flush_d = 1; step();
        idle(); step();
        // Repeated load-use stalls drive the narrow counter into saturation
        idle(); MemRead_d = 1; RegWrite_d = 1; rs_d = 3; rt_d = 3;
        for (int i = 0; i < 12; i++) step();
        // Reset during a stall
        idle(); MemRead_d = 1; RegWrite_d = 1; rt_d = 3; step();
        idle(); rs_d = 3; reset = 1; step();
        idle(); rs_d = 3; step();
        idle(); step();
        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            if ($urandom_range(0, 49) == 0) reset = 1;
            step();
        end
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
